// File: rtl/bcd_converter.sv
// bcd_converter: sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional BCD_CONVERTER_AUTO_START_EN: self-triggers a conversion after reset and whenever bin changes.
module bcd_converter #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_WIDTH-1:0]     bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGITS-1:0][3:0]  bcd,
    output logic                    overflow
);
    localparam int INT_DIGITS = (IN_WIDTH * 301) / 1000 + 1;
    localparam int SD = INT_DIGITS > DIGITS ? INT_DIGITS : DIGITS;
    localparam int SW = SD * 4;
    localparam int CW = $clog2(IN_WIDTH + 1);
    typedef enum logic {IDLE, CONVERT} state_t;
    state_t                  state;
    logic [IN_WIDTH-1:0]     shreg;
    logic [SW-1:0]           scratch;
    logic [SW-1:0]           adj;
    logic [SW-1:0]           nxt;
    logic [CW-1:0]           count;
    logic [DIGITS-1:0][3:0]  bcd_next;
    logic                    ovf_next;
    logic                    go;
    for (genvar d = 0; d < SD; d++) begin : g_adj
        assign adj[4*d +: 4] = scratch[4*d +: 4] >= 4'd5 ? scratch[4*d +: 4] + 4'd3 : scratch[4*d +: 4];
    end
    // Adjusted top bit always falls off: INT_DIGITS is sized so it is never set.
    assign nxt = SW'({adj, shreg[IN_WIDTH-1]});
    for (genvar d = 0; d < DIGITS; d++) begin : g_bcd
        assign bcd_next[d] = nxt[4*(DIGITS-1-d) +: 4];
    end
    if (SD > DIGITS) begin : g_ovf
        assign ovf_next = |nxt[SW-1:4*DIGITS];
    end else begin : g_no_ovf
        assign ovf_next = 1'b0;
    end
`ifdef BCD_CONVERTER_AUTO_START_EN
    logic [IN_WIDTH-1:0] last_bin;
    logic                pending;
    assign go = start || pending || (bin != last_bin);
`else
    assign go = start;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
`ifdef BCD_CONVERTER_AUTO_START_EN
            last_bin <= '0;
            pending  <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (go) begin
                    shreg   <= bin;
                    scratch <= '0;
                    count   <= '0;
                    busy    <= 1'b1;
                    state   <= CONVERT;
`ifdef BCD_CONVERTER_AUTO_START_EN
                    last_bin <= bin;
                    pending  <= 1'b0;
`endif
                end
            end else begin
                shreg   <= shreg << 1;
                scratch <= nxt;
                count   <= count + 1'b1;
                if (count == CW'(IN_WIDTH - 1)) begin
                    bcd      <= bcd_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: directed checks of conversion results, latency, handshake, overflow and reset abort.
module tb_bcd_converter;
    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     bin;
    logic            busy;
    logic            done;
    logic [3:0][3:0] bcd;
    logic            overflow;
    int              total = 0;
    int              passed = 0;
    int              n;
    int              dones;
    bcd_converter #(.IN_WIDTH(16), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] digits();
        return {bcd[0], bcd[1], bcd[2], bcd[3]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic convert(input string tag, input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        logic [15:0] prev;
        logic        prev_ovf;
        prev = digits();
        prev_ovf = overflow;
        bin = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (n == 8) begin
                chk({tag, "_hold_bcd"}, digits(), prev);
                chk({tag, "_hold_ovf"}, overflow, prev_ovf);
            end
        end
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_bcd"}, digits(), exp_bcd);
        chk({tag, "_ovf"}, overflow, exp_ovf);
        chk({tag, "_busy_low"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        bin = '0;
        repeat (2) tick();
        chk("rst_bcd", digits(), 16'h0000);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        convert("zero", 16'd0, 16'h0000, 1'b0);
        convert("d9999", 16'd9999, 16'h9999, 1'b0);
        convert("d1234", 16'd1234, 16'h1234, 1'b0);
        convert("d12345", 16'd12345, 16'h2345, 1'b1);
        convert("d65535", 16'd65535, 16'h5535, 1'b1);
        // Start held high; bin changes mid-conversion and must be ignored.
        bin = 16'd7;
        start = 1'b1;
        tick();
        chk("hs_busy", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (n == 3) bin = 16'd42;
        end
        chk("hs_latency1", n, 16);
        chk("hs_bcd1", digits(), 16'h0007);
        chk("hs_ovf1", overflow, 0);
        tick();
        start = 1'b0;
        chk("hs_b2b_busy", busy, 1);
        chk("hs_b2b_done", done, 0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("hs_latency2", n, 16);
        chk("hs_bcd2", digits(), 16'h0042);
        tick();
        // Abort a conversion of 500 partway through.
        bin = 16'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_bcd", digits(), 16'h0000);
        chk("abort_ovf", overflow, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        convert("d500", 16'd500, 16'h0500, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
